// File: rtl/flip_pkg.sv
// Shared types and helpers for the flip_deser serial receiver.
// bit_reverse() is the reference word flip used by benches.
package flip_pkg;

    localparam int FLIP_W = 8;

    typedef enum logic {ST_DATA, ST_PAR} flip_state_t;

    function automatic logic [FLIP_W-1:0] bit_reverse(input logic [FLIP_W-1:0] word);
        logic [FLIP_W-1:0] r;
        for (int i = 0; i < FLIP_W; i++) r[i] = word[FLIP_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/flip_out_reg.sv
// One-entry valid/ready holding register for the reassembled word.
// A load always wins; the parent only loads when the slot is free or draining.
module flip_out_reg
    import flip_pkg::*;
#(
    parameter int WIDTH = FLIP_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_perr,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_perr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_perr  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= ld_data;
            m_perr  <= ld_perr;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/flip_deser.sv
// Serial-to-parallel receiver for an LSB-first link with valid/ready word output.
// Define FLIP_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module flip_deser
    import flip_pkg::*;
#(
    parameter int WIDTH     = FLIP_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_sof,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             m_perr
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    flip_state_t      state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sr, sr_nxt, ld_data;
    logic             accept, last_pos, complete, pending, ld_perr;

`ifdef FLIP_DESER_PARITY_EN
    // The data word is already final in sr; the parity bit only closes the frame.
    assign last_pos = (state == ST_PAR);
    assign ld_data  = sr;
    assign ld_perr  = (^sr) ^ s_bit;
`else
    assign last_pos = (bit_cnt == LAST);
    assign ld_data  = sr_nxt;
    assign ld_perr  = 1'b0;
`endif

    assign pending  = (bit_cnt != '0) || (state == ST_PAR);
    // Stall only the bit that would need the occupied output slot; a realigning
    // s_sof never completes a word, so it is never held off.
    assign s_ready  = !(last_pos && !(s_valid && s_sof) && m_valid && !m_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && !s_sof && last_pos;

    always_comb begin
        sr_nxt = sr;
        if (s_sof)
            sr_nxt = LSB_FIRST ? {s_bit, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_bit};
        else
            sr_nxt = LSB_FIRST ? {s_bit, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], s_bit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_DATA;
            bit_cnt   <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && s_sof && pending;
            if (accept) begin
                if (s_sof) begin
                    state   <= ST_DATA;
                    bit_cnt <= CW'(1);
                    sr      <= sr_nxt;
                end else if (state == ST_PAR) begin
                    state <= ST_DATA;
                end else begin
                    sr <= sr_nxt;
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
`ifdef FLIP_DESER_PARITY_EN
                        state   <= ST_PAR;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    flip_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (complete),
        .ld_data (ld_data),
        .ld_perr (ld_perr),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_perr  (m_perr)
    );

endmodule

// File: tb/tb_flip_deser.sv
// Scoreboard bench for flip_deser: LSB_FIRST=1 and LSB_FIRST=0 instances share stimulus.
// Honours FLIP_DESER_PARITY_EN (sends a trailing parity bit per word).
module tb_flip_deser;
    import flip_pkg::*;

    localparam int W = 8;
`ifdef FLIP_DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + PAR;

    logic clk = 1'b0, reset_n = 1'b0;
    logic s_valid = 1'b0, s_bit = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
    logic s_ready_l, m_valid_l, frame_err_l, m_perr_l;
    logic s_ready_m, m_valid_m, frame_err_m, m_perr_m;
    logic [W-1:0] m_data_l, m_data_m;

    flip_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
        .s_ready(s_ready_l), .m_valid(m_valid_l), .m_data(m_data_l), .m_ready(m_ready),
        .frame_err(frame_err_l), .m_perr(m_perr_l));

    flip_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
        .s_ready(s_ready_m), .m_valid(m_valid_m), .m_data(m_data_m), .m_ready(m_ready),
        .frame_err(frame_err_m), .m_perr(m_perr_m));

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] wl; logic [W-1:0] wm; logic p; } exp_t;
    exp_t q[$];
    logic bits[$];
    logic ferr_next = 1'b0;
    int   ferr_seen = 0;
    int   checks = 0, failures = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted bits; frame of NB bits -> one word.
    task automatic model_accept(input logic b, input logic sof);
        logic [W-1:0] w;
        logic p;
        if (sof) begin
            if (bits.size() != 0) ferr_next = 1'b1;
            bits.delete();
        end
        bits.push_back(b);
        if (bits.size() == NB) begin
            w = '0;
            for (int k = 0; k < W; k++) w[k] = bits[k];
            p = (PAR != 0) ? ((^w) ^ bits[W]) : 1'b0;
            q.push_back('{wl: w, wm: bit_reverse(w), p: p});
            bits.delete();
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_bit   = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof, output int waits);
        logic acc;
        s_valid = 1'b1; s_bit = b; s_sof = sof; waits = 0;
        forever begin
            @(negedge clk);
            acc = s_ready_l;
            @(posedge clk);
            if (acc) begin
                model_accept(b, sof);
                break;
            end
            waits++;
            if (waits > 300) begin
                check("send_timeout", 32'(waits), 0);
                break;
            end
        end
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_bit = 1'($urandom);
    endtask

    function automatic logic frame_bit(input logic [W-1:0] w, input logic flip, input int k);
        return (k < W) ? w[k] : ((^w) ^ flip);
    endfunction

    task automatic send_word(input logic [W-1:0] w, input logic flip, input logic sof0);
        int wt;
        for (int k = 0; k < NB; k++) send_bit(frame_bit(w, flip, k), (k == 0) ? sof0 : 1'b0, wt);
    endtask

    // m_ready driver
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Monitor: compares both instances against the scoreboard every cycle.
    initial forever begin
        logic exp_v, exp_sr;
        @(negedge clk);
        exp_v  = (q.size() != 0);
        exp_sr = !((bits.size() == NB - 1) && !(s_valid && s_sof) && exp_v && !m_ready);
        check("m_valid_l", 32'(m_valid_l), 32'(exp_v));
        check("m_valid_m", 32'(m_valid_m), 32'(exp_v));
        check("s_ready_l", 32'(s_ready_l), 32'(exp_sr));
        check("s_ready_m", 32'(s_ready_m), 32'(exp_sr));
        check("frame_err_l", 32'(frame_err_l), 32'(ferr_next));
        check("frame_err_m", 32'(frame_err_m), 32'(ferr_next));
        if (frame_err_l) ferr_seen++;
        ferr_next = 1'b0;
        if (exp_v) begin
            check("m_data_l", 32'(m_data_l), 32'(q[0].wl));
            check("m_data_m", 32'(m_data_m), 32'(q[0].wm));
            check("m_perr_l", 32'(m_perr_l), 32'(q[0].p));
            check("m_perr_m", 32'(m_perr_m), 32'(q[0].p));
            if (m_ready) void'(q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, f0, n;
        logic [W-1:0] rw;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_m_valid", 32'(m_valid_l), 0);
        check("rst_m_data", 32'(m_data_l), 0);
        check("rst_s_ready", 32'(s_ready_l), 1);
        check("rst_frame_err", 32'(frame_err_l), 0);
        check("rst_m_perr", 32'(m_perr_l), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // 0xA1 / 0x85, one-cycle completion latency and single-cycle valid
        rdy_val = 1'b1;
        idle(1);
        send_word(8'hA1, 1'b0, 1'b1);
        @(negedge clk);
        check("a1_valid", 32'(m_valid_l), 1);
        check("a1_lsb", 32'(m_data_l), 32'h A1);
        check("a1_msb", 32'(m_data_m), 32'h 85);
        check("a1_perr", 32'(m_perr_l), 0);
        @(negedge clk);
        check("a1_valid_drop", 32'(m_valid_l), 0);
        idle(1);

`ifdef FLIP_DESER_PARITY_EN
        // Completion is timed from the parity bit, and bad parity is flagged
        for (int k = 0; k < W; k++) send_bit(frame_bit(8'hA1, 1'b0, k), k == 0, wt);
        @(negedge clk);
        check("par_wait_valid", 32'(m_valid_l), 0);
        idle(1);
        send_bit(frame_bit(8'hA1, 1'b0, W), 1'b0, wt);
        @(negedge clk);
        check("par_ok_valid", 32'(m_valid_l), 1);
        check("par_ok_perr", 32'(m_perr_l), 0);
        idle(1);
        send_word(8'hA1, 1'b1, 1'b1);
        @(negedge clk);
        check("par_bad_perr", 32'(m_perr_l), 1);
        idle(1);
`endif

        // Backpressure: 0x3C held, 0x5A stalls only on its last bit
        rdy_val = 1'b0;
        idle(2);
        send_word(8'h3C, 1'b0, 1'b1);
        for (int k = 0; k < NB - 1; k++) begin
            send_bit(frame_bit(8'h5A, 1'b0, k), k == 0, wt);
            check("bp_early_accept", 32'(wt), 0);
        end
        s_valid = 1'b1; s_bit = frame_bit(8'h5A, 1'b0, NB - 1); s_sof = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_s_ready_low", 32'(s_ready_l), 0);
            check("bp_hold_3c", 32'(m_data_l), 32'h3C);
        end
        rdy_val = 1'b1;
        send_bit(frame_bit(8'h5A, 1'b0, NB - 1), 1'b0, wt);
        idle(4);
        check("bp_drained", 32'(q.size()), 0);

        // s_sof after 3 bits: framing error, then 0xFF decodes
        f0 = ferr_seen;
        for (int k = 0; k < 3; k++) send_bit(1'($urandom), k == 0, wt);
        send_word(8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        check("sof_ff", 32'(m_data_l), 32'hFF);
        idle(2);
        check("sof_ferr_count", 32'(ferr_seen - f0), 1);

        // Reset with a held word and a partial word pending
        rdy_val = 1'b0;
        idle(2);
        send_word(8'h96, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) send_bit(1'($urandom), k == 0, wt);
        #2;
        reset_n = 1'b0;
        q.delete();
        bits.delete();
        ferr_next = 1'b0;
        #1;
        check("mid_rst_valid_l", 32'(m_valid_l), 0);
        check("mid_rst_data_l", 32'(m_data_l), 0);
        check("mid_rst_valid_m", 32'(m_valid_m), 0);
        check("mid_rst_data_m", 32'(m_data_m), 0);
        check("mid_rst_s_ready", 32'(s_ready_l), 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rdy_val = 1'b1;
        idle(2);
        send_word(8'h01, 1'b0, 1'b1);
        @(negedge clk);
        check("post_rst_01", 32'(m_data_l), 32'h01);
        idle(2);

        // Randomized traffic: partial frames, optional realign, random m_ready
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(1, NB - 1);
                for (int k = 0; k < n; k++) send_bit(1'($urandom), k == 0, wt);
            end else begin
                rw = W'($urandom);
                send_word(rw, (PAR != 0) ? 1'($urandom) : 1'b0, 1'($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        idle(20);
        check("final_drain", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flip_deser.md
Name: flip_deser

Overview:
- Serial-to-parallel receiver: the far end of a link whose transmitter shifts out bit-reversed (LSB-first) words.
- Collects WIDTH serial bits and reassembles them into the original word order.
- Presents the word on a valid/ready output with single-word holding.
- Sits between a 1-bit serial link and byte-wide datapath logic.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- LSB_FIRST, 1. 1: received bit k lands in m_data[k]. 0: received bit k lands in m_data[WIDTH-1-k].

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- s_valid  input  1  serial bit valid
- s_bit  input  1  serial data bit
- s_sof  input  1  start-of-word marker, qualified by s_valid; forces the current bit to be bit 0
- s_ready  output  1  receiver can accept the current bit
- m_valid  output  1  output word valid
- m_data  output  WIDTH  reassembled word
- m_ready  input  1  downstream accepts word
- frame_err  output  1  one-cycle pulse: s_sof arrived while a partial word was pending
- m_perr  output  1  parity error flag for the word on m_data (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by the integrating design):
  - bit_cnt=0, shift register=0, state=DATA.
  - m_valid=0, m_data=0, frame_err=0, m_perr=0.
  - s_ready=1 after reset.
  - Reset mid-word discards the partial word and any held output word.
- Bit transfer: a bit is accepted only when s_valid&&s_ready at the clock edge.
- Shifting:
  - LSB_FIRST=1: shift right, new bit enters the MSB.
  - LSB_FIRST=0: shift left, new bit enters the LSB.
  - After WIDTH accepts, the shift register holds the word in final order.
- bit_cnt: counts 0..WIDTH-1 and wraps to 0 on completion. Width is $clog2(WIDTH).
- States:
  - DATA: collect bits.
  - PAR: exists only with the optional feature.
- Completion (last data bit accepted, no parity):
  - Next cycle m_data=assembled word and m_valid=1.
  - Latency: 1 cycle from the accept of the last bit to m_valid.
- Output handshake:
  - m_valid stays high, and m_data stays stable, until m_valid&&m_ready.
  - No combinational path from m_ready to m_valid.
- Backpressure:
  - s_ready=0 only when the next accept would complete a word while m_valid&&!m_ready.
  - Bits 0..WIDTH-2 of the next word are still accepted while a word is held.
  - Completion in the same cycle as m_ready handshake: s_ready=1, the new word is loaded, and m_valid stays 1.
  - Words are never dropped or overwritten.
- s_sof:
  - Accepted bit with s_sof=1 is stored as bit 0, and bit_cnt restarts at 1.
  - If bit_cnt!=0 at that time, frame_err pulses high for 1 cycle (registered) and the partial word is discarded.
  - s_sof when bit_cnt==0 is a legal no-op realignment.
- s_bit is ignored when s_valid=0.
- WIDTH=2 edge: the backpressure rule applies on bit 1.

Optional Feature:
- Macro: FLIP_DESER_PARITY_EN.
- When defined:
  - After the WIDTH data bits, the FSM enters PAR and accepts one extra bit, the even-parity bit over the data word.
  - The backpressure rule applies to the parity bit instead of the last data bit.
  - The word is presented 1 cycle after parity accept.
  - m_perr = (^word) ^ parity_bit, registered with m_data and valid while m_valid.
  - s_sof during PAR is a framing error (frame_err pulse, restart).
- When undefined:
  - No PAR state; m_perr is tied to 0.

Decomposition:
- Shared package flip_pkg:
  - localparam FLIP_W=8
  - state enum {ST_DATA, ST_PAR}
  - function bit_reverse(word), used by benches as the golden model.
- Sub-module flip_out_reg: the one-entry valid/ready output holding register (load, m_valid, m_data, m_perr). Everything else stays in flip_deser.

Test Plan:
- LSB_FIRST=1, m_ready=1, send bits 1,0,0,0,0,1,0,1 (s_sof on first) -> m_data=0xA1, m_valid high exactly 1 cycle, 1 cycle after the 8th accept.
- LSB_FIRST=0, same bit sequence -> m_data=0x85.
- m_ready=0: send 0x3C then 0x5A back-to-back -> 0x3C held stable; s_ready drops only on the 8th bit of 0x5A; raise m_ready -> 0x3C then 0x5A delivered in order, no loss.
- s_sof asserted after 3 bits of a word -> frame_err pulses 1 cycle; the following 8 bits encoding 0xFF yield m_data=0xFF.
- reset_n asserted low mid-word (bit 5) and with m_valid=1 -> m_valid=0 and m_data=0 immediately; a subsequent word 0x01 is decoded correctly.
- FLIP_DESER_PARITY_EN: 0xA1 with parity 1 -> m_perr=0; with parity 0 -> m_perr=1; completion latency measured from the parity bit.
